// File: rtl/lemon_wb_pkg.sv
// lemon_wb_pkg: shared definitions for the LemonPC writeback stage.
//   - wb_state_e : writeback FSM states
//   - LB..LWU    : RV64 load funct3 encodings
//   - BEAT_BYTES : bytes per data-memory beat
//   - load_misaligned(): size-alignment test used when WB_MISALIGN_CHECK_EN is defined
package lemon_wb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    WB   = 2'd3
  } wb_state_e;

  localparam logic [2:0] LB  = 3'b000;
  localparam logic [2:0] LH  = 3'b001;
  localparam logic [2:0] LW  = 3'b010;
  localparam logic [2:0] LD  = 3'b011;
  localparam logic [2:0] LBU = 3'b100;
  localparam logic [2:0] LHU = 3'b101;
  localparam logic [2:0] LWU = 3'b110;

  localparam int unsigned BEAT_BYTES = 8;

  // funct3 111 is handled as LD, so it needs full 8-byte alignment.
  function automatic logic load_misaligned(input logic [2:0] funct3, input logic [2:0] off);
    case (funct3)
      LB, LBU:  load_misaligned = 1'b0;
      LH, LHU:  load_misaligned = off[0];
      LW, LWU:  load_misaligned = |off[1:0];
      default:  load_misaligned = |off;
    endcase
  endfunction

endpackage

// File: rtl/writeback_unit_load_extract.sv
// load_extract: combinational byte alignment and sign/zero extension of a
// 64-bit memory beat.
//   data   : read beat
//   off    : byte offset of the load address within the beat
//   funct3 : RV64 load type
//   value  : extended result for the register file
// Bytes shifted past the top of the beat read as zero before extension.
module load_extract
  import lemon_wb_pkg::*;
(
  input  logic [63:0] data,
  input  logic [2:0]  off,
  input  logic [2:0]  funct3,
  output logic [63:0] value
);

  logic [63:0] s;

  always_comb begin
    s = data >> {off, 3'b000};
    case (funct3)
      LB:      value = {{56{s[7]}},  s[7:0]};
      LH:      value = {{48{s[15]}}, s[15:0]};
      LW:      value = {{32{s[31]}}, s[31:0]};
      LBU:     value = {56'd0, s[7:0]};
      LHU:     value = {48'd0, s[15:0]};
      LWU:     value = {32'd0, s[31:0]};
      default: value = s;
    endcase
  end

endmodule

// File: rtl/writeback_unit.sv
// writeback_unit: final LemonPC pipeline stage driving the register file write
// port. Non-load results retire one per cycle; loads issue a single aligned
// 64-bit read, wait for the response, extract and write back.
// Ports:
//   clk, rst                : clock, synchronous active-high reset
//   in_valid/in_ready       : execute-result handshake (ready only in IDLE)
//   in_rd/in_wen/in_is_load/in_funct3/in_result : execute result
//   mem_req_valid/ready/addr: data-memory read request (8-byte aligned)
//   mem_resp_valid/data     : data-memory read response
//   rd/wen/dataD            : register file write port (registered)
//   misalign                : one-cycle misaligned-load pulse
//   busy                    : FSM not in IDLE
// Build option: define WB_MISALIGN_CHECK_EN to reject loads that are not
// size-aligned (no request, misalign pulse, no write). Otherwise misalign is 0.
module writeback_unit
  import lemon_wb_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 5,
  parameter int unsigned DATA_WIDTH = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [ADDR_WIDTH-1:0] in_rd,
  input  logic                  in_wen,
  input  logic                  in_is_load,
  input  logic [2:0]            in_funct3,
  input  logic [DATA_WIDTH-1:0] in_result,
  output logic                  mem_req_valid,
  input  logic                  mem_req_ready,
  output logic [DATA_WIDTH-1:0] mem_req_addr,
  input  logic                  mem_resp_valid,
  input  logic [DATA_WIDTH-1:0] mem_resp_data,
  output logic [ADDR_WIDTH-1:0] rd,
  output logic                  wen,
  output logic [DATA_WIDTH-1:0] dataD,
  output logic                  misalign,
  output logic                  busy
);

  wb_state_e             state_q, state_d;
  logic [ADDR_WIDTH-1:0] rd_q, rd_d;
  logic                  wen_q, wen_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  misalign_q, misalign_d;
  logic                  req_valid_q, req_valid_d;
  logic [DATA_WIDTH-1:0] req_addr_q, req_addr_d;
  logic                  lwen_q, lwen_d;
  logic [2:0]            funct3_q, funct3_d;
  logic [2:0]            off_q, off_d;
  logic [DATA_WIDTH-1:0] load_value;
  logic                  accept;
  logic                  reject_load;

  load_extract u_extract (
    .data   (mem_resp_data),
    .off    (off_q),
    .funct3 (funct3_q),
    .value  (load_value)
  );

  assign accept = in_valid && (state_q == IDLE);

`ifdef WB_MISALIGN_CHECK_EN
  assign reject_load = load_misaligned(in_funct3, in_result[2:0]);
`else
  assign reject_load = 1'b0;
`endif

  // State and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      rd_q        <= '0;
      wen_q       <= 1'b0;
      data_q      <= '0;
      misalign_q  <= 1'b0;
      req_valid_q <= 1'b0;
      req_addr_q  <= '0;
      lwen_q      <= 1'b0;
      funct3_q    <= '0;
      off_q       <= '0;
    end else begin
      state_q     <= state_d;
      rd_q        <= rd_d;
      wen_q       <= wen_d;
      data_q      <= data_d;
      misalign_q  <= misalign_d;
      req_valid_q <= req_valid_d;
      req_addr_q  <= req_addr_d;
      lwen_q      <= lwen_d;
      funct3_q    <= funct3_d;
      off_q       <= off_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (accept && in_is_load && !reject_load) state_d = REQ;
      REQ:  if (mem_req_ready) state_d = WAIT;
      WAIT: if (mem_resp_valid) state_d = WB;
      WB:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output / datapath logic. The load write enable is computed on the response
  // cycle so that the registered wen is high while the FSM sits in WB.
  always_comb begin
    rd_d        = rd_q;
    wen_d       = 1'b0;
    data_d      = data_q;
    misalign_d  = 1'b0;
    req_valid_d = req_valid_q;
    req_addr_d  = req_addr_q;
    lwen_d      = lwen_q;
    funct3_d    = funct3_q;
    off_d       = off_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (!in_is_load) begin
            rd_d   = in_rd;
            data_d = in_result;
            wen_d  = in_wen && (in_rd != '0);
          end else if (reject_load) begin
            misalign_d = 1'b1;
          end else begin
            rd_d        = in_rd;
            lwen_d      = in_wen;
            funct3_d    = in_funct3;
            off_d       = in_result[2:0];
            req_addr_d  = {in_result[DATA_WIDTH-1:3], 3'b000};
            req_valid_d = 1'b1;
          end
        end
      end
      REQ: begin
        if (mem_req_ready) req_valid_d = 1'b0;
      end
      WAIT: begin
        if (mem_resp_valid) begin
          data_d = load_value;
          wen_d  = lwen_q && (rd_q != '0);
        end
      end
      default: ;
    endcase
  end

  assign in_ready      = (state_q == IDLE);
  assign busy          = (state_q != IDLE);
  assign rd            = rd_q;
  assign wen           = wen_q;
  assign dataD         = data_q;
  assign misalign      = misalign_q;
  assign mem_req_valid = req_valid_q;
  assign mem_req_addr  = req_addr_q;

endmodule

// File: tb/tb_writeback_unit.sv
// Directed self-checking bench for writeback_unit. Inputs change and outputs
// are sampled 1 time unit after each rising clock edge.
module tb_writeback_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  in_rd;
  logic        in_wen;
  logic        in_is_load;
  logic [2:0]  in_funct3;
  logic [63:0] in_result;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic [63:0] mem_req_addr;
  logic        mem_resp_valid;
  logic [63:0] mem_resp_data;
  logic [4:0]  rd;
  logic        wen;
  logic [63:0] dataD;
  logic        misalign;
  logic        busy;

  int checks = 0;
  int failures = 0;

  writeback_unit #(.ADDR_WIDTH(5), .DATA_WIDTH(64)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_rd(in_rd), .in_wen(in_wen),
    .in_is_load(in_is_load), .in_funct3(in_funct3), .in_result(in_result),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_req_addr(mem_req_addr), .mem_resp_valid(mem_resp_valid),
    .mem_resp_data(mem_resp_data), .rd(rd), .wen(wen), .dataD(dataD),
    .misalign(misalign), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; in_rd = '0; in_wen = 1'b0; in_is_load = 1'b0;
    in_funct3 = '0; in_result = '0; mem_req_ready = 1'b0;
    mem_resp_valid = 1'b0; mem_resp_data = '0;
    tick(); tick();
    rst = 1'b0;
    checks++; if (wen !== 1'b0) begin failures++; $display("FAIL reset_wen got=%b exp=0", wen); end
    checks++; if (rd !== 5'd0) begin failures++; $display("FAIL reset_rd got=%0d exp=0", rd); end
    checks++; if (dataD !== 64'd0) begin failures++; $display("FAIL reset_dataD got=%h exp=0", dataD); end
    checks++; if (mem_req_valid !== 1'b0 || mem_req_addr !== 64'd0) begin failures++; $display("FAIL reset_req got=%b/%h exp=0/0", mem_req_valid, mem_req_addr); end
    checks++; if (misalign !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1) begin failures++; $display("FAIL reset_flags got mis=%b busy=%b rdy=%b exp 0/0/1", misalign, busy, in_ready); end
  endtask

  task automatic test_alu();
    in_valid = 1'b1; in_is_load = 1'b0; in_wen = 1'b1; in_rd = 5'd5; in_result = 64'h1234;
    tick();
    in_valid = 1'b0;
    checks++; if (wen !== 1'b1 || rd !== 5'd5 || dataD !== 64'h1234) begin failures++; $display("FAIL alu_write got wen=%b rd=%0d data=%h exp 1/5/1234", wen, rd, dataD); end
    checks++; if (in_ready !== 1'b1 || busy !== 1'b0) begin failures++; $display("FAIL alu_ready got rdy=%b busy=%b exp 1/0", in_ready, busy); end
    tick();
    checks++; if (wen !== 1'b0) begin failures++; $display("FAIL alu_wen_pulse got=%b exp=0", wen); end
  endtask

  task automatic test_back_to_back();
    for (int i = 1; i <= 3; i++) begin
      in_valid = 1'b1; in_is_load = 1'b0; in_wen = 1'b1;
      in_rd = 5'(i + 10); in_result = 64'hA000 + 64'(i);
      tick();
      checks++;
      if (wen !== 1'b1 || rd !== 5'(i + 10) || dataD !== 64'hA000 + 64'(i)) begin
        failures++; $display("FAIL b2b_%0d got wen=%b rd=%0d data=%h exp 1/%0d/%h", i, wen, rd, dataD, i + 10, 64'hA000 + 64'(i));
      end
    end
    in_valid = 1'b0;
    tick();
    checks++; if (wen !== 1'b0) begin failures++; $display("FAIL b2b_idle got wen=%b exp=0", wen); end
  endtask

  task automatic test_rd_zero();
    in_valid = 1'b1; in_is_load = 1'b0; in_wen = 1'b1; in_rd = 5'd0; in_result = 64'h55AA;
    tick();
    in_valid = 1'b0;
    checks++; if (wen !== 1'b0) begin failures++; $display("FAIL rd0_wen got=%b exp=0", wen); end
    checks++; if (dataD !== 64'h55AA) begin failures++; $display("FAIL rd0_data got=%h exp=55aa", dataD); end
    in_valid = 1'b1; in_wen = 1'b0; in_rd = 5'd7; in_result = 64'h77;
    tick();
    in_valid = 1'b0;
    checks++; if (wen !== 1'b0 || rd !== 5'd7) begin failures++; $display("FAIL nowen got wen=%b rd=%0d exp 0/7", wen, rd); end
  endtask

  // One load transaction: accept, hold request for ready_delay cycles, then
  // response after resp_delay cycles in WAIT.
  task automatic test_load(input string name, input logic [63:0] addr, input logic [2:0] f3,
                           input logic [4:0] dst, input int ready_delay, input int resp_delay,
                           input logic [63:0] resp, input logic [63:0] exp_data, input logic exp_wen);
    logic [63:0] exp_addr;
    exp_addr = {addr[63:3], 3'b000};
    in_valid = 1'b1; in_is_load = 1'b1; in_wen = 1'b1; in_rd = dst;
    in_funct3 = f3; in_result = addr; mem_req_ready = 1'b0;
    tick();
    in_valid = 1'b0; in_is_load = 1'b0;
    checks++; if (mem_req_valid !== 1'b1 || mem_req_addr !== exp_addr || wen !== 1'b0 || in_ready !== 1'b0) begin
      failures++; $display("FAIL %s_req got v=%b a=%h wen=%b rdy=%b exp 1/%h/0/0", name, mem_req_valid, mem_req_addr, wen, in_ready, exp_addr);
    end
    for (int i = 0; i < ready_delay; i++) begin
      in_valid = 1'b1;  // must be ignored while busy
      tick();
      checks++; if (mem_req_valid !== 1'b1 || mem_req_addr !== exp_addr || in_ready !== 1'b0 || wen !== 1'b0) begin
        failures++; $display("FAIL %s_hold%0d got v=%b a=%h rdy=%b wen=%b exp 1/%h/0/0", name, i, mem_req_valid, mem_req_addr, in_ready, wen, exp_addr);
      end
    end
    in_valid = 1'b0;
    mem_req_ready = 1'b1;
    tick();
    mem_req_ready = 1'b0;
    checks++; if (mem_req_valid !== 1'b0 || busy !== 1'b1 || in_ready !== 1'b0) begin
      failures++; $display("FAIL %s_wait got v=%b busy=%b rdy=%b exp 0/1/0", name, mem_req_valid, busy, in_ready);
    end
    for (int i = 0; i < resp_delay; i++) tick();
    mem_resp_valid = 1'b1; mem_resp_data = resp;
    tick();
    mem_resp_valid = 1'b0;
    checks++; if (wen !== exp_wen || rd !== dst || dataD !== exp_data) begin
      failures++; $display("FAIL %s_wb got wen=%b rd=%0d data=%h exp %b/%0d/%h", name, wen, rd, dataD, exp_wen, dst, exp_data);
    end
    tick();
    checks++; if (wen !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
      failures++; $display("FAIL %s_done got wen=%b rdy=%b busy=%b exp 0/1/0", name, wen, in_ready, busy);
    end
  endtask

  task automatic test_loads();
    test_load("lb",  64'h1003, 3'b000, 5'd3, 0, 0, 64'h00000000_80000000, 64'hFFFFFFFF_FFFFFF80, 1'b1);
    test_load("lbu", 64'h1003, 3'b100, 5'd4, 0, 1, 64'h00000000_80000000, 64'h00000000_00000080, 1'b1);
    test_load("lw",  64'h2004, 3'b010, 5'd8, 3, 2, 64'h89ABCDEF_00000000, 64'hFFFFFFFF_89ABCDEF, 1'b1);
    test_load("lwu", 64'h2004, 3'b110, 5'd9, 0, 0, 64'h89ABCDEF_00000000, 64'h00000000_89ABCDEF, 1'b1);
    test_load("lh",  64'h1006, 3'b001, 5'd10, 1, 0, 64'h8001_0000_0000_0000, 64'hFFFFFFFF_FFFF8001, 1'b1);
    test_load("lhu", 64'h1006, 3'b101, 5'd11, 0, 0, 64'h8001_0000_0000_0000, 64'h00000000_00008001, 1'b1);
    test_load("ld_rd0", 64'h4000, 3'b011, 5'd0, 0, 0, 64'hDEADBEEF_CAFEF00D, 64'hDEADBEEF_CAFEF00D, 1'b0);
    test_load("f111", 64'h4008, 3'b111, 5'd12, 0, 0, 64'h01234567_89ABCDEF, 64'h01234567_89ABCDEF, 1'b1);
  endtask

  task automatic test_misalign();
`ifdef WB_MISALIGN_CHECK_EN
    in_valid = 1'b1; in_is_load = 1'b1; in_wen = 1'b1; in_rd = 5'd6;
    in_funct3 = 3'b011; in_result = 64'h3004;
    tick();
    in_valid = 1'b0; in_is_load = 1'b0;
    checks++; if (misalign !== 1'b1 || mem_req_valid !== 1'b0 || wen !== 1'b0 || in_ready !== 1'b1) begin
      failures++; $display("FAIL mis_pulse got mis=%b v=%b wen=%b rdy=%b exp 1/0/0/1", misalign, mem_req_valid, wen, in_ready);
    end
    tick();
    checks++; if (misalign !== 1'b0 || mem_req_valid !== 1'b0 || wen !== 1'b0) begin
      failures++; $display("FAIL mis_after got mis=%b v=%b wen=%b exp 0/0/0", misalign, mem_req_valid, wen);
    end
`else
    test_load("ld_mis", 64'h3004, 3'b011, 5'd6, 0, 0, 64'h11223344_55667788, 64'h00000000_11223344, 1'b1);
    checks++; if (misalign !== 1'b0) begin failures++; $display("FAIL mis_tied got=%b exp=0", misalign); end
`endif
  endtask

  task automatic test_reset_in_wait();
    in_valid = 1'b1; in_is_load = 1'b1; in_wen = 1'b1; in_rd = 5'd13;
    in_funct3 = 3'b011; in_result = 64'h5000; mem_req_ready = 1'b1;
    tick();
    in_valid = 1'b0; in_is_load = 1'b0;
    tick();
    mem_req_ready = 1'b0;
    checks++; if (busy !== 1'b1 || mem_req_valid !== 1'b0) begin failures++; $display("FAIL rstw_pre got busy=%b v=%b exp 1/0", busy, mem_req_valid); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++; if (busy !== 1'b0 || in_ready !== 1'b1 || wen !== 1'b0 || dataD !== 64'd0) begin
      failures++; $display("FAIL rstw_idle got busy=%b rdy=%b wen=%b data=%h exp 0/1/0/0", busy, in_ready, wen, dataD);
    end
    mem_resp_valid = 1'b1; mem_resp_data = 64'hFFFF_0000_FFFF_0000;
    tick();
    mem_resp_valid = 1'b0;
    checks++; if (wen !== 1'b0 || busy !== 1'b0 || dataD !== 64'd0) begin
      failures++; $display("FAIL rstw_late got wen=%b busy=%b data=%h exp 0/0/0", wen, busy, dataD);
    end
    tick();
    checks++; if (wen !== 1'b0 || in_ready !== 1'b1) begin failures++; $display("FAIL rstw_end got wen=%b rdy=%b exp 0/1", wen, in_ready); end
  endtask

  initial begin
    test_reset();
    test_alu();
    test_back_to_back();
    test_rd_zero();
    test_loads();
    test_misalign();
    test_reset_in_wait();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/writeback_unit.md
# writeback_unit

Final pipeline stage of LemonPC, directly upstream of the register file: accepts completed execute results through a valid/ready handshake and drives the register file write port (`rd`, `wen`, `dataD`). For loads it issues one 64-bit read to data memory, waits for the response, then aligns and sign/zero-extends the selected bytes before writing. Non-load results retire at one per cycle; loads block the stage until written back.

## Interface
- `ADDR_WIDTH`, 5, register index width (must match register file)
- `DATA_WIDTH`, 64, register and memory beat width; 64 is the only supported value
- `clk` input 1 clock; all logic on posedge
- `rst` input 1 synchronous, active-high reset
- `in_valid` input 1 execute result valid
- `in_ready` output 1 stage can accept
- `in_rd` input ADDR_WIDTH destination register
- `in_wen` input 1 instruction writes `in_rd`
- `in_is_load` input 1 `in_result` is a load address
- `in_funct3` input 3 load type (RV64 encoding)
- `in_result` input DATA_WIDTH ALU result or load byte address
- `mem_req_valid` output 1 read request
- `mem_req_ready` input 1 memory accepts request
- `mem_req_addr` output DATA_WIDTH 8-byte-aligned address
- `mem_resp_valid` input 1 read data valid
- `mem_resp_data` input DATA_WIDTH read beat
- `rd` output ADDR_WIDTH to register file
- `wen` output 1 to register file
- `dataD` output DATA_WIDTH to register file
- `misalign` output 1 one-cycle misaligned-load pulse
- `busy` output 1 state != IDLE

## Operation
- FSM states: IDLE, REQ, WAIT, WB. `in_ready = (state == IDLE)`.
- IDLE, accept non-load: next cycle `rd=in_rd`, `dataD=in_result`, `wen=in_wen && in_rd!=0` for exactly one cycle; stay IDLE (back-to-back accepts allowed).
- IDLE, accept load: latch rd/wen/funct3/address; go REQ; `wen=0`.
- REQ: `mem_req_valid=1`, `mem_req_addr = addr & ~7`, held stable until `mem_req_ready`; then WAIT.
- WAIT: on `mem_resp_valid`, register extracted value into `dataD`; go WB. `mem_resp_valid` in any other state is ignored.
- WB: `wen = latched_wen && rd!=0` for one cycle; go IDLE.
- Extraction: `off = addr[2:0]`, `s = mem_resp_data >> (8*off)`. funct3 000 LB, 001 LH, 010 LW, 011 LD sign-extend from 8/16/32/64 bits; 100 LBU, 101 LHU, 110 LWU zero-extend; 111 treated as LD.
- `wen` never asserts for `rd==0`; `dataD` still updates.

## Timing
- Reset values: state IDLE, `wen=0`, `rd=0`, `dataD=0`, `misalign=0`, `mem_req_valid=0`, `mem_req_addr=0`, `busy=0`, `in_ready=1` in the cycle after reset.
- Non-load accepted cycle N: `wen` high cycle N+1.
- Load accepted N: `mem_req_valid` high from N+1. If `mem_req_ready` at N+1, WAIT from N+2. Response at cycle M: `wen` high M+1. Minimum load latency accept-to-write is 3 cycles.
- `rst` in any state aborts the transaction: no write, request dropped, return to IDLE next cycle.
- All outputs except `in_ready` and `busy` are registered.

## Configuration
- `WB_MISALIGN_CHECK_EN` defined: a load whose address is not size-aligned (LH/LHU `off[0]`, LW/LWU `off[1:0]`, LD `off[2:0]`) issues no memory request. `misalign` pulses in cycle N+1, `wen=0`, state stays IDLE.
- Undefined: `misalign` tied 0. Misaligned loads proceed normally; bytes shifted beyond the beat read as zero before extension.

## Structure
- Package `lemon_wb_pkg`: FSM state encoding; load funct3 constants (`LB`…`LWU`); beat size constant 8.
- Sub-module `load_extract`: combinational `(data, off, funct3) -> value` shift/extend, instantiated once.

## Test plan
- ALU op `in_rd=5`, `in_result=0x1234`, accepted N -> `wen=1`, `rd=5`, `dataD=0x1234` at N+1; three consecutive accepts give three consecutive writes.
- `in_rd=0`, `in_wen=1` -> `wen` stays 0.
- LB addr `0x1003`, resp `0x00000000_80000000` -> `mem_req_addr=0x1000`, `dataD=0xFFFFFFFF_FFFFFF80`; LBU same -> `0x80`.
- LW addr `0x2004`, `mem_req_ready` delayed 3 cycles, resp `0x89ABCDEF_00000000` -> request held stable, `in_ready=0` throughout, `dataD=0xFFFFFFFF_89ABCDEF`.
- With `WB_MISALIGN_CHECK_EN`, LD addr `0x3004` -> `mem_req_valid` never asserts, `misalign` pulse at N+1, no write. Without the macro -> request to `0x3000`, resp `0x11223344_55667788` gives `dataD=0x11223344`.
- `rst` asserted during WAIT, then late `mem_resp_valid` -> no `wen`, state IDLE, response ignored.
